raizing_snd_mailbox: RTL and testbench

Parametrised main-CPU ↔ sound-CPU mailbox for the Raizing sound subsystems: NCH command channels from the 68k to the Z80 (plain latches or FIFOs, selected by MODE), NCH reply registers from the Z80 to the 68k, and the NMI/WAIT handshake. It replaces the hard-wired SOUNDLATCH..SOUNDLATCH4 registers and NMI/wait flip-flops in the per-game sound modules. It runs entirely in the 96 MHz sound domain. The main-CPU bus is already synchronised to that domain by the caller.

---
 rtl/raizing_snd_mailbox.sv | 168 ++++++++++++++++
 tb/tb_raizing_snd_mailbox.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/raizing_snd_mailbox.sv
// Main-CPU <-> sound-CPU mailbox: NCH command channels (latch or FIFO), NCH reply
// registers and the NMI/WAIT handshake, all in the 96 MHz sound domain.
module raizing_snd_mailbox #(
   parameter int NCH   = 2,
   parameter int DEPTH = 4,
   parameter int MODE  = 1,
   localparam int SW   = (NCH == 1) ? 1 : $clog2(NCH)
) (
   input  logic            CLK96,
   input  logic            RESET96,
   input  logic            M_WR,
   input  logic            M_RD,
   input  logic [SW-1:0]   M_SEL,
   input  logic [7:0]      M_DIN,
   output logic [7:0]      M_DOUT,
   output logic            M_WAIT,
   output logic [NCH-1:0]  M_FULL,
   output logic            SNDIRQ,
   input  logic            S_WR,
   input  logic            S_RD,
   input  logic [SW-1:0]   S_SEL,
   input  logic [7:0]      S_DIN,
   output logic [7:0]      S_DOUT,
   output logic [NCH-1:0]  S_AVAIL,
   output logic            NMI_N,
   input  logic            NMI_CLR,
   output logic [NCH-1:0]  OVF
);

   logic [NCH-1:0] w_m_sel, w_s_sel, w_m_wr, w_fresh_nxt;
   logic           w_m_ok, w_s_ok;
   logic [7:0]     w_reply_mux;

   logic [7:0]     r_reply [NCH];
   logic [NCH-1:0] r_fresh;
   logic [7:0]     r_m_dout, r_s_dout;
   logic           r_irq, r_pend;
   logic [NCH-1:0] r_avail, r_full, r_ovf;

   // Out-of-range selects match no channel, so mux defaults double as the 8'hFF read value
   always_comb begin
      w_m_sel     = '0;
      w_s_sel     = '0;
      w_fresh_nxt = '0;
      w_reply_mux = '1;
      for (int unsigned i = 0; i < NCH; i++) begin
         w_m_sel[i] = (M_SEL == SW'(i));
         w_s_sel[i] = (S_SEL == SW'(i));
         w_fresh_nxt[i] = (S_WR && w_s_sel[i]) || (r_fresh[i] && !(M_RD && w_m_sel[i]));
         if (w_m_sel[i]) w_reply_mux = r_reply[i];
      end
   end

   assign w_m_ok = |w_m_sel;
   assign w_s_ok = |w_s_sel;
   assign w_m_wr = w_m_sel & {NCH{M_WR}};

   always_ff @(posedge CLK96) begin
      if (RESET96) begin
         for (int unsigned i = 0; i < NCH; i++) r_reply[i] <= '0;
         r_fresh  <= '0;
         r_irq    <= 1'b0;
         r_m_dout <= '0;
         r_pend   <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NCH; i++)
            if (S_WR && w_s_sel[i]) r_reply[i] <= S_DIN;
         r_fresh <= w_fresh_nxt;
         r_irq   <= |w_fresh_nxt;
         if (M_RD) r_m_dout <= w_reply_mux;
         if (M_WR && w_m_ok) r_pend <= 1'b1;
         else if (NMI_CLR)   r_pend <= 1'b0;
      end
   end

   if (MODE == 1) begin : g_fifo
      localparam int AW = $clog2(DEPTH);
      localparam int CW = AW + 1;

      logic [7:0]     r_mem  [NCH][DEPTH];
      logic [AW-1:0]  r_wptr [NCH];
      logic [AW-1:0]  r_rptr [NCH];
      logic [CW-1:0]  r_cnt  [NCH];
      logic [CW-1:0]  w_cnt_nxt [NCH];
      logic [NCH-1:0] w_pop, w_acc;
      logic [7:0]     w_head;

      // A full FIFO still accepts a push when the same cycle pops it
      always_comb begin
         w_pop  = '0;
         w_acc  = '0;
         w_head = '1;
         for (int unsigned i = 0; i < NCH; i++) begin
            w_pop[i] = S_RD && w_s_sel[i] && (r_cnt[i] != '0);
            w_acc[i] = w_m_wr[i] && ((r_cnt[i] != CW'(DEPTH)) || w_pop[i]);
            w_cnt_nxt[i] = r_cnt[i] + CW'(w_acc[i]) - CW'(w_pop[i]);
            if (w_s_sel[i]) w_head = r_mem[i][r_rptr[i]];
         end
      end

      always_ff @(posedge CLK96) begin
         if (RESET96) begin
            for (int unsigned i = 0; i < NCH; i++) begin
               for (int unsigned j = 0; j < DEPTH; j++) r_mem[i][j] <= '0;
               r_wptr[i] <= '0;
               r_rptr[i] <= '0;
               r_cnt[i]  <= '0;
            end
            r_avail  <= '0;
            r_full   <= '0;
            r_ovf    <= '0;
            r_s_dout <= '0;
         end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
               if (w_acc[i]) begin
                  r_mem[i][r_wptr[i]] <= M_DIN;
                  r_wptr[i] <= r_wptr[i] + AW'(1);
               end
               if (w_pop[i]) r_rptr[i] <= r_rptr[i] + AW'(1);
               r_cnt[i]   <= w_cnt_nxt[i];
               r_avail[i] <= (w_cnt_nxt[i] != '0);
               r_full[i]  <= (w_cnt_nxt[i] == CW'(DEPTH));
               if (w_m_wr[i] && !w_acc[i]) r_ovf[i] <= 1'b1;
            end
            if (S_RD && (!w_s_ok || (|w_pop))) r_s_dout <= w_head;
         end
      end
   end else begin : g_latch
      logic [7:0] r_cmd [NCH];
      logic [7:0] w_cmd_mux;

      always_comb begin
         w_cmd_mux = '1;
         for (int unsigned i = 0; i < NCH; i++)
            if (w_s_sel[i]) w_cmd_mux = r_cmd[i];
      end

      always_ff @(posedge CLK96) begin
         if (RESET96) begin
            for (int unsigned i = 0; i < NCH; i++) r_cmd[i] <= '0;
            r_avail  <= '0;
            r_s_dout <= '0;
         end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
               if (w_m_wr[i]) begin
                  r_cmd[i]   <= M_DIN;
                  r_avail[i] <= 1'b1;
               end else if (S_RD && w_s_sel[i]) begin
                  r_avail[i] <= 1'b0;
               end
            end
            if (S_RD) r_s_dout <= w_cmd_mux;
         end
         r_full <= '0;
         r_ovf  <= '0;
      end
   end

   assign M_DOUT  = r_m_dout;
   assign M_WAIT  = r_pend;
   assign NMI_N   = ~r_pend;
   assign SNDIRQ  = r_irq;
   assign M_FULL  = r_full;
   assign OVF     = r_ovf;
   assign S_DOUT  = r_s_dout;
   assign S_AVAIL = r_avail;

endmodule

// File: tb/tb_raizing_snd_mailbox.sv
// Directed bench: FIFO-mode, latch-mode and NCH=3 instances of the sound mailbox.
module tb_raizing_snd_mailbox;

   logic clk = 1'b0;
   logic rst;
   logic m_wr, m_rd, s_wr, s_rd, nmi_clr;
   logic m_sel, s_sel;
   logic [1:0] m_sel3, s_sel3;
   logic [7:0] m_din, s_din;

   logic [7:0] f_mdout, f_sdout, l_mdout, l_sdout, s3_mdout, s3_sdout;
   logic f_wait, f_irq, f_nmin, l_wait, l_irq, l_nmin, s3_wait, s3_irq, s3_nmin;
   logic [1:0] f_full, f_avail, f_ovf, l_full, l_avail, l_ovf;
   logic [2:0] s3_full, s3_avail, s3_ovf;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   raizing_snd_mailbox #(.NCH(2), .DEPTH(4), .MODE(1)) u_f (
      .CLK96(clk), .RESET96(rst), .M_WR(m_wr), .M_RD(m_rd), .M_SEL(m_sel), .M_DIN(m_din),
      .M_DOUT(f_mdout), .M_WAIT(f_wait), .M_FULL(f_full), .SNDIRQ(f_irq),
      .S_WR(s_wr), .S_RD(s_rd), .S_SEL(s_sel), .S_DIN(s_din), .S_DOUT(f_sdout),
      .S_AVAIL(f_avail), .NMI_N(f_nmin), .NMI_CLR(nmi_clr), .OVF(f_ovf));

   raizing_snd_mailbox #(.NCH(2), .DEPTH(4), .MODE(0)) u_l (
      .CLK96(clk), .RESET96(rst), .M_WR(m_wr), .M_RD(m_rd), .M_SEL(m_sel), .M_DIN(m_din),
      .M_DOUT(l_mdout), .M_WAIT(l_wait), .M_FULL(l_full), .SNDIRQ(l_irq),
      .S_WR(s_wr), .S_RD(s_rd), .S_SEL(s_sel), .S_DIN(s_din), .S_DOUT(l_sdout),
      .S_AVAIL(l_avail), .NMI_N(l_nmin), .NMI_CLR(nmi_clr), .OVF(l_ovf));

   raizing_snd_mailbox #(.NCH(3), .DEPTH(4), .MODE(1)) u_s (
      .CLK96(clk), .RESET96(rst), .M_WR(m_wr), .M_RD(m_rd), .M_SEL(m_sel3), .M_DIN(m_din),
      .M_DOUT(s3_mdout), .M_WAIT(s3_wait), .M_FULL(s3_full), .SNDIRQ(s3_irq),
      .S_WR(s_wr), .S_RD(s_rd), .S_SEL(s_sel3), .S_DIN(s_din), .S_DOUT(s3_sdout),
      .S_AVAIL(s3_avail), .NMI_N(s3_nmin), .NMI_CLR(nmi_clr), .OVF(s3_ovf));

   // {S_DOUT, S_AVAIL, M_FULL, OVF, NMI_N, M_WAIT, SNDIRQ, M_DOUT}
   logic [24:0] out_f;
   assign out_f = {f_sdout, f_avail, f_full, f_ovf, f_nmin, f_wait, f_irq, f_mdout};

   typedef struct {
      logic       wr;
      logic       msel;
      logic [7:0] din;
      logic       srd;
      logic       ssel;
      logic       clr;
      logic       swr;
      logic [7:0] sdin;
      logic       mrd;
      logic [24:0] exp;
   } vec_t;

   function automatic vec_t mk(input logic wr, input logic msel, input logic [7:0] din,
                               input logic srd, input logic ssel, input logic clr,
                               input logic swr, input logic [7:0] sdin, input logic mrd,
                               input logic [7:0] e_sd, input logic [1:0] e_av,
                               input logic [1:0] e_fu, input logic [1:0] e_ov,
                               input logic e_nmi, input logic e_wt, input logic e_irq,
                               input logic [7:0] e_md);
      vec_t v;
      v.wr = wr; v.msel = msel; v.din = din; v.srd = srd; v.ssel = ssel;
      v.clr = clr; v.swr = swr; v.sdin = sdin; v.mrd = mrd;
      v.exp = {e_sd, e_av, e_fu, e_ov, e_nmi, e_wt, e_irq, e_md};
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic idle();
      m_wr = 0; m_rd = 0; s_wr = 0; s_rd = 0; nmi_clr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic push1(input logic ch, input logic [7:0] d);
      m_wr = 1; m_sel = ch; m_din = d;
      step();
   endtask

   task automatic pop1(input logic ch);
      s_rd = 1; s_sel = ch;
      step();
   endtask

   vec_t tbl [18];
   logic [7:0] exp_q [4];

   initial begin
      idle();
      m_sel = 0; s_sel = 0; m_sel3 = 0; s_sel3 = 0; m_din = 0; s_din = 0;
      rst = 1;
      step();
      step();
      rst = 0;
      chk("reset_state", out_f, {8'h00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00});

      //         wr ms din    rd ss clr swr sdin  mrd  sdout  av    fu    ov   nmi wt irq mdout
      tbl[0]  = mk(1, 0, 8'h11, 0, 0, 0, 0, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 0, 1, 0, 8'h00);
      tbl[1]  = mk(1, 0, 8'h22, 0, 0, 0, 0, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 0, 1, 0, 8'h00);
      tbl[2]  = mk(1, 0, 8'h33, 0, 0, 0, 0, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 0, 1, 0, 8'h00);
      tbl[3]  = mk(1, 0, 8'h44, 0, 0, 0, 0, 8'h00, 0, 8'h00, 2'b01, 2'b01, 2'b00, 0, 1, 0, 8'h00);
      tbl[4]  = mk(1, 0, 8'h55, 0, 0, 0, 0, 8'h00, 0, 8'h00, 2'b01, 2'b01, 2'b01, 0, 1, 0, 8'h00);
      tbl[5]  = mk(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 8'h11, 2'b01, 2'b00, 2'b01, 1, 0, 0, 8'h00);
      tbl[6]  = mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h22, 2'b01, 2'b00, 2'b01, 1, 0, 0, 8'h00);
      tbl[7]  = mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h33, 2'b01, 2'b00, 2'b01, 1, 0, 0, 8'h00);
      tbl[8]  = mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h44, 2'b00, 2'b00, 2'b01, 1, 0, 0, 8'h00);
      tbl[9]  = mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h44, 2'b00, 2'b00, 2'b01, 1, 0, 0, 8'h00);
      tbl[10] = mk(1, 1, 8'h01, 0, 0, 0, 0, 8'h00, 0, 8'h44, 2'b10, 2'b00, 2'b01, 0, 1, 0, 8'h00);
      tbl[11] = mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 8'h44, 2'b10, 2'b00, 2'b01, 1, 0, 0, 8'h00);
      tbl[12] = mk(1, 1, 8'h02, 0, 0, 1, 0, 8'h00, 0, 8'h44, 2'b10, 2'b00, 2'b01, 0, 1, 0, 8'h00);
      tbl[13] = mk(0, 0, 8'h00, 0, 1, 1, 1, 8'h7E, 0, 8'h44, 2'b10, 2'b00, 2'b01, 1, 0, 1, 8'h00);
      tbl[14] = mk(0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h44, 2'b10, 2'b00, 2'b01, 1, 0, 0, 8'h7E);
      tbl[15] = mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h44, 2'b10, 2'b00, 2'b01, 1, 0, 0, 8'h00);
      tbl[16] = mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h5A, 1, 8'h44, 2'b10, 2'b00, 2'b01, 1, 0, 1, 8'h00);
      tbl[17] = mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h44, 2'b10, 2'b00, 2'b01, 1, 0, 0, 8'h5A);

      for (int i = 0; i < 18; i++) begin
         m_wr = tbl[i].wr; m_sel = tbl[i].msel; m_din = tbl[i].din;
         s_rd = tbl[i].srd; s_sel = tbl[i].ssel; nmi_clr = tbl[i].clr;
         s_wr = tbl[i].swr; s_din = tbl[i].sdin; m_rd = tbl[i].mrd;
         step();
         chk($sformatf("vec%0d", i), out_f, tbl[i].exp);
      end

      // Pointer wrap on ch1
      do_reset();
      for (int k = 0; k < 10; k++) begin
         push1(1'b1, 8'(k));
         pop1(1'b1);
         chk($sformatf("wrap_rd%0d", k), f_sdout, k);
      end
      chk("wrap_ovf", f_ovf, 2'b00);
      chk("wrap_avail", f_avail, 2'b00);

      // Full boundary: simultaneous push+pop keeps count at DEPTH
      for (int k = 0; k < 4; k++) push1(1'b1, 8'(8'hA0 + k));
      chk("full_set", f_full, 2'b10);
      m_wr = 1; m_sel = 1; m_din = 8'hB0; s_rd = 1; s_sel = 1;
      step();
      chk("full_pp_dout", f_sdout, 8'hA0);
      chk("full_pp_full", f_full, 2'b10);
      chk("full_pp_ovf", f_ovf, 2'b00);
      exp_q[0] = 8'hA1; exp_q[1] = 8'hA2; exp_q[2] = 8'hA3; exp_q[3] = 8'hB0;
      for (int k = 0; k < 4; k++) begin
         pop1(1'b1);
         chk($sformatf("full_drain%0d", k), f_sdout, exp_q[k]);
      end
      chk("full_drain_avail", f_avail, 2'b00);

      // Empty boundary: no bypass
      m_wr = 1; m_sel = 1; m_din = 8'hA5; s_rd = 1; s_sel = 1;
      step();
      chk("empty_pp_dout", f_sdout, 8'hB0);
      chk("empty_pp_avail", {f_avail, f_full}, 4'b1000);
      pop1(1'b1);
      chk("empty_next_rd", f_sdout, 8'hA5);
      chk("empty_next_avail", f_avail, 2'b00);

      // Reset mid-operation with 3 entries queued
      for (int k = 1; k <= 4; k++) push1(1'b0, 8'(k));
      pop1(1'b0);
      s_wr = 1; s_sel = 0; s_din = 8'h66;
      step();
      m_rd = 1; m_sel = 0;
      step();
      s_wr = 1; s_sel = 1; s_din = 8'h77;
      step();
      chk("pre_rst", out_f, {8'h01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 8'h66});
      do_reset();
      chk("mid_rst", out_f, {8'h00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00});
      pop1(1'b0);
      chk("post_rst_rd", {f_sdout, f_avail}, {8'h00, 2'b00});

      // Latch mode
      do_reset();
      push1(1'b0, 8'h10);
      push1(1'b0, 8'h20);
      chk("lat_avail", l_avail, 2'b01);
      pop1(1'b0);
      chk("lat_rd1", {l_sdout, l_avail}, {8'h20, 2'b00});
      pop1(1'b0);
      chk("lat_rd2", l_sdout, 8'h20);
      m_wr = 1; m_sel = 0; m_din = 8'h30; s_rd = 1; s_sel = 0;
      step();
      chk("lat_wr_rd", {l_sdout, l_avail}, {8'h20, 2'b01});
      pop1(1'b0);
      chk("lat_rd3", l_sdout, 8'h30);
      for (int k = 0; k < 6; k++) push1(1'b1, 8'(k));
      chk("lat_full_ovf", {l_full, l_ovf, l_avail}, {2'b00, 2'b00, 2'b10});

      // Out-of-range select on NCH=3
      do_reset();
      m_wr = 1; m_sel3 = 2'd3; m_din = 8'h99;
      step();
      chk("sel_wr_ign", {s3_nmin, s3_wait, s3_avail, s3_ovf}, {1'b1, 1'b0, 3'b000, 3'b000});
      m_rd = 1; m_sel3 = 2'd3;
      step();
      chk("sel_mrd_ff", s3_mdout, 8'hFF);
      s_rd = 1; s_sel3 = 2'd3;
      step();
      chk("sel_srd_ff", s3_sdout, 8'hFF);
      m_wr = 1; m_sel3 = 2'd2; m_din = 8'h42;
      step();
      chk("sel_ch2_wr", {s3_nmin, s3_avail}, {1'b0, 3'b100});
      s_rd = 1; s_sel3 = 2'd2;
      step();
      chk("sel_ch2_rd", s3_sdout, 8'h42);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
